// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, flag bit
// positions and the controller state encoding.
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4;
  localparam logic [5:0] ALU_NOT = 6'd5;
  localparam logic [5:0] ALU_LSL = 6'd6;
  localparam logic [5:0] ALU_LSR = 6'd7;
  localparam logic [5:0] ALU_RSL = 6'd8;
  localparam logic [5:0] ALU_RSR = 6'd9;
  localparam logic [5:0] ALU_INC = 6'd10;
  localparam logic [5:0] ALU_DEC = 6'd11;
  localparam logic [5:0] ALU_CMP = 6'd12;
  localparam logic [5:0] ALU_TST = 6'd13;
  localparam logic [5:0] ALU_MUL = 6'd14;
  localparam logic [5:0] ALU_DIV = 6'd15;
  localparam logic [5:0] ALU_MOD = 6'd16;
  localparam logic [5:0] ALU_NOP = 6'd17;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [5:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per
// cycle for WIDTH cycles after load. {hi,lo} is product or {remainder,quotient}.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             is_mul;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    nxt_hi  = hi;
    nxt_lo  = lo;
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    shifted = {hi, lo[WIDTH-1]};
    trial   = shifted - {1'b0, opb};
    if (is_mul) begin
      nxt_hi = add_sum[WIDTH:1];
      nxt_lo = {add_sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      // Partial remainder >= divisor: keep the subtraction, quotient bit 1.
      nxt_hi = trial[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = shifted[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking (<=) so all registers sample pre-edge values.
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      is_mul <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
    end else if (load) begin
      opa    <= a;
      opb    <= b;
      is_mul <= (op == ALU_MUL);
      hi     <= '0;
      lo     <= (op == ALU_MUL) ? b : a;
      cnt    <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops finish in
// IDLE; MUL/DIV/MOD hand off to seq_alu_iter and finish through FIN.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [WIDTH-1:0] W_LIT = WIDTH[WIDTH-1:0];

  state_t state, state_next;
  logic [5:0] op_q;

  logic iter_load, iter_last, fire, fin;
  logic is_div, div0;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  logic [WIDTH:0]   add_ext, sub_ext, inc_ext, dec_ext, lsl_ext, lsr_ext;
  logic [WIDTH-1:0] rot_amt, rsl_val, rsr_val;

  logic [WIDTH-1:0] res_val, sc_result, fin_result;
  logic [3:0]       sc_flags, fin_flags;
  logic             c_f, o_f, wr_res, wr_flg;

  seq_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (iter_load),
    .op   (opcode),
    .a    (a),
    .b    (b),
    .lo   (iter_lo),
    .hi   (iter_hi),
    .last (iter_last)
  );

  assign is_div  = (opcode == ALU_DIV) || (opcode == ALU_MOD);
  assign div0    = is_div && (b == '0);
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign inc_ext = {1'b0, a} + (WIDTH+1)'(1);
  assign dec_ext = {1'b0, a} - (WIDTH+1)'(1);
  assign lsl_ext = {1'b0, a} << b;
  assign lsr_ext = {a, 1'b0} >> b;
  assign rot_amt = b % W_LIT;
  assign rsl_val = (a << rot_amt) | (a >> (W_LIT - rot_amt));
  assign rsr_val = (a >> rot_amt) | (a << (W_LIT - rot_amt));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    iter_load  = 1'b0;
    fire       = 1'b0;
    fin        = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (is_iter_op(opcode) && !div0) begin
          iter_load  = 1'b1;
          state_next = ITER;
        end else begin
          fire = 1'b1;
        end
      end
      ITER: if (iter_last) state_next = FIN;
      FIN: begin
        fin        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops; the rotate carry is the bit that wrapped around.
  always_comb begin
    res_val = result;
    c_f     = 1'b0;
    o_f     = 1'b0;
    wr_res  = 1'b0;
    wr_flg  = 1'b0;
    case (opcode)
      ALU_ADD: begin
        res_val = add_ext[WIDTH-1:0];
        c_f     = add_ext[WIDTH];
        o_f     = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_SUB, ALU_CMP: begin
        res_val = sub_ext[WIDTH-1:0];
        c_f     = sub_ext[WIDTH];
        o_f     = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
        wr_res  = (opcode == ALU_SUB);
        wr_flg  = 1'b1;
      end
      ALU_INC: begin
        res_val = inc_ext[WIDTH-1:0];
        c_f     = inc_ext[WIDTH];
        o_f     = !a[WIDTH-1] && inc_ext[WIDTH-1];
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_DEC: begin
        res_val = dec_ext[WIDTH-1:0];
        c_f     = dec_ext[WIDTH];
        o_f     = a[WIDTH-1] && !dec_ext[WIDTH-1];
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_AND: begin res_val = a & b; {wr_res, wr_flg} = 2'b11; end
      ALU_OR:  begin res_val = a | b; {wr_res, wr_flg} = 2'b11; end
      ALU_XOR: begin res_val = a ^ b; {wr_res, wr_flg} = 2'b11; end
      ALU_NOT: begin res_val = ~a;    {wr_res, wr_flg} = 2'b11; end
      ALU_TST: begin res_val = a & b; wr_flg = 1'b1; end
      ALU_LSL: begin
        res_val = lsl_ext[WIDTH-1:0];
        c_f     = lsl_ext[WIDTH];
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_LSR: begin
        res_val = lsr_ext[WIDTH:1];
        c_f     = lsr_ext[0];
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_RSL: begin
        res_val = rsl_val;
        c_f     = rsl_val[0];
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_RSR: begin
        res_val = rsr_val;
        c_f     = rsr_val[WIDTH-1];
        {wr_res, wr_flg} = 2'b11;
      end
      ALU_DIV, ALU_MOD: if (div0) begin
        res_val = (opcode == ALU_DIV) ? '1 : a;
        o_f     = 1'b1;
        {wr_res, wr_flg} = 2'b11;
      end
      default: ;
    endcase

    sc_result = wr_res ? res_val : result;
    sc_flags  = flags;
    if (wr_flg) begin
      sc_flags[FLAG_Z] = (res_val == '0) && !div0;
      sc_flags[FLAG_N] = res_val[WIDTH-1];
      sc_flags[FLAG_C] = c_f;
      sc_flags[FLAG_O] = o_f;
    end
  end

  always_comb begin
    fin_result        = (op_q == ALU_MOD) ? iter_hi : iter_lo;
    fin_flags         = '0;
    fin_flags[FLAG_Z] = (fin_result == '0);
    fin_flags[FLAG_N] = fin_result[WIDTH-1];
    fin_flags[FLAG_C] = (op_q == ALU_MUL) && (iter_hi != '0);
    fin_flags[FLAG_O] = (op_q == ALU_MUL) && (iter_hi != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (iter_load) op_q <= opcode;
      if (fire) begin
        done   <= 1'b1;
        result <= sc_result;
        flags  <= sc_flags;
        err    <= div0;
      end else if (fin) begin
        done   <= 1'b1;
        result <= fin_result;
        flags  <= fin_flags;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a vector table at WIDTH=16 plus hand-written
// sequences for busy, back-to-back, reset abort and a WIDTH=8 instance.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic [5:0]  opcode;
  logic [15:0] a16, b16;

  logic        busy16, done16, err16;
  logic [15:0] result16;
  logic [3:0]  flags16;
  logic        busy8, done8, err8;
  logic [7:0]  result8;
  logic [3:0]  flags8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .opcode(opcode), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .flags(flags16), .err(err16)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .opcode(opcode), .a(a16[7:0]), .b(b16[7:0]),
    .busy(busy8), .done(done8), .result(result8), .flags(flags8), .err(err8)
  );

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_op(input bit w8, input logic [5:0] op, input logic [15:0] aa,
                        input logic [15:0] bb, output int lat);
    @(negedge clk);
    opcode = op;
    a16    = aa;
    b16    = bb;
    if (w8) start8 = 1'b1;
    else    start16 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    lat     = 1;
    while (!(w8 ? done8 : done16) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_cnt, done_cnt;

    // Flags column is {Z,N,C,O}; CMP/TST/NOP rows carry the previous result.
    vecs[0]  = '{ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'h5, 1'b0, 1};
    vecs[1]  = '{ALU_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'h6, 1'b0, 1};
    vecs[2]  = '{ALU_CMP, 16'h0005, 16'h0005, 16'hFFFE, 4'h8, 1'b0, 1};
    vecs[3]  = '{ALU_DIV, 16'd100,  16'd7,    16'd14,   4'h0, 1'b0, 18};
    vecs[4]  = '{ALU_MOD, 16'd100,  16'd7,    16'd2,    4'h0, 1'b0, 18};
    vecs[5]  = '{ALU_DIV, 16'd1234, 16'd0,    16'hFFFF, 4'h5, 1'b1, 1};
    vecs[6]  = '{ALU_RSL, 16'h8001, 16'd17,   16'h0003, 4'h2, 1'b0, 1};
    vecs[7]  = '{ALU_LSR, 16'h8000, 16'd20,   16'h0000, 4'h8, 1'b0, 1};
    vecs[8]  = '{ALU_LSL, 16'h8001, 16'd1,    16'h0002, 4'h2, 1'b0, 1};
    vecs[9]  = '{ALU_LSL, 16'h0001, 16'd16,   16'h0000, 4'hA, 1'b0, 1};
    vecs[10] = '{ALU_LSR, 16'h0003, 16'd1,    16'h0001, 4'h2, 1'b0, 1};
    vecs[11] = '{ALU_RSR, 16'h0003, 16'd1,    16'h8001, 4'h6, 1'b0, 1};
    vecs[12] = '{ALU_AND, 16'hFF0F, 16'h0FF0, 16'h0F00, 4'h0, 1'b0, 1};
    vecs[13] = '{ALU_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'h8, 1'b0, 1};
    vecs[14] = '{ALU_NOT, 16'h00FF, 16'h0000, 16'hFF00, 4'h4, 1'b0, 1};
    vecs[15] = '{ALU_INC, 16'hFFFF, 16'h0000, 16'h0000, 4'hA, 1'b0, 1};
    vecs[16] = '{ALU_DEC, 16'h8000, 16'h0000, 16'h7FFF, 4'h1, 1'b0, 1};
    vecs[17] = '{ALU_TST, 16'h00F0, 16'h0F00, 16'h7FFF, 4'h8, 1'b0, 1};
    vecs[18] = '{ALU_NOP, 16'h1234, 16'h5678, 16'h7FFF, 4'h8, 1'b0, 1};
    vecs[19] = '{6'h3F,   16'h1234, 16'h5678, 16'h7FFF, 4'h8, 1'b0, 1};
    vecs[20] = '{ALU_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 4'h4, 1'b0, 18};
    vecs[21] = '{ALU_MOD, 16'h0005, 16'h0000, 16'h0005, 4'h1, 1'b1, 1};
    vecs[22] = '{ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'hA, 1'b0, 1};
    vecs[23] = '{ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'h1, 1'b0, 1};

    rst = 1'b1; start16 = 1'b0; start8 = 1'b0; opcode = ALU_NOP; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   busy16,   1'b0);
    check("reset done",   done16,   1'b0);
    check("reset result", result16, 16'h0);
    check("reset flags",  flags16,  4'h0);
    check("reset err",    err16,    1'b0);
    check("reset8 busy",  busy8,    1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), lat,      vecs[i].lat);
      check($sformatf("vec%0d result", i),  result16, vecs[i].res);
      check($sformatf("vec%0d flags", i),   flags16,  vecs[i].flg);
      check($sformatf("vec%0d err", i),     err16,    vecs[i].err);
      check($sformatf("vec%0d busy", i),    busy16,   1'b0);
    end

    // MUL with extra start pulses while busy (mid-ITER and in FIN).
    @(negedge clk);
    opcode = ALU_MUL; a16 = 16'h0100; b16 = 16'h0100; start16 = 1'b1;
    @(negedge clk);
    lat = 1; busy_cnt = 0;
    while (!done16 && lat < 40) begin
      if (busy16) busy_cnt++;
      start16 = (lat == 5) || (lat == 17);
      opcode  = start16 ? ALU_ADD : ALU_MUL;
      a16     = 16'h0001;
      b16     = 16'h0001;
      @(negedge clk);
      lat++;
    end
    start16 = 1'b0;
    check("mul latency",     lat,      18);
    check("mul busy cycles", busy_cnt, 17);
    check("mul result",      result16, 16'h0000);
    check("mul flags",       flags16,  4'hB);
    check("mul busy at done", busy16,  1'b0);
    @(negedge clk);
    check("mul dropped start done", done16,   1'b0);
    check("mul dropped start res",  result16, 16'h0000);

    // Start in the done cycle is accepted.
    run_op(1'b0, ALU_DIV, 16'd100, 16'd7, lat);
    check("b2b div latency", lat, 18);
    opcode = ALU_ADD; a16 = 16'd1; b16 = 16'd1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check("b2b add done",   done16,   1'b1);
    check("b2b add result", result16, 16'd2);

    // Reset in the 5th cycle of a DIV aborts it.
    @(negedge clk);
    opcode = ALU_DIV; a16 = 16'd100; b16 = 16'd7; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",   busy16,   1'b0);
    check("abort done",   done16,   1'b0);
    check("abort result", result16, 16'h0);
    check("abort flags",  flags16,  4'h0);
    done_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done16) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    run_op(1'b0, ALU_ADD, 16'd2, 16'd3, lat);
    check("post-abort add latency", lat,      1);
    check("post-abort add result",  result16, 16'd5);
    check("post-abort add flags",   flags16,  4'h0);

    // WIDTH=8 instance.
    run_op(1'b1, ALU_ADD, 16'h007F, 16'h0001, lat);
    check("w8 add latency", lat,     1);
    check("w8 add result",  result8, 8'h80);
    check("w8 add flags",   flags8,  4'h5);
    run_op(1'b1, ALU_MUL, 16'h0010, 16'h0010, lat);
    check("w8 mul latency", lat,     10);
    check("w8 mul result",  result8, 8'h00);
    check("w8 mul flags",   flags8,  4'hB);
    run_op(1'b1, ALU_MUL, 16'h000F, 16'h0011, lat);
    check("w8 mul2 latency", lat,     10);
    check("w8 mul2 result",  result8, 8'hFF);
    check("w8 mul2 flags",   flags8,  4'h4);
    check("w8 mul2 err",     err8,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
